// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, handshake FSM states and
// the operation select of the iterative multiply/divide core.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MUL = 4'b0100,
    OP_MOD = 4'b0101
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    MdMul,
    MdDiv,
    MdMod
  } md_op_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// SEQ_ALU_MOD_EN exposes the remainder as a result.
module alu_muldiv_core
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  md_op_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Division keeps {remainder, dividend/quotient} in acc and shifts both left together.
  logic [2*WIDTH-1:0] acc_q, acc_d, x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  md_op_e             op_q, op_d;
  logic [WIDTH:0]     partial, diff;

  assign done = busy_q && (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = partial - {1'b0, x_q[WIDTH-1:0]};
    if (start) begin
      op_d   = op;
      busy_d = 1'b1;
      cnt_d  = '0;
      y_d    = b;
      if (op == MdMul) begin
        acc_d = '0;
        x_d   = {{WIDTH{1'b0}}, a};
      end else begin
        acc_d = {{WIDTH{1'b0}}, a};
        x_d   = {{WIDTH{1'b0}}, b};
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (op_q == MdMul) begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end else if (!diff[WIDTH]) begin
        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= MdMul;
    end else begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      op_q   <= op_d;
    end
  end

  always_comb begin
    case (op_q)
      MdMul:   result = acc_q;
`ifdef SEQ_ALU_MOD_EN
      MdMod:   result = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
`endif
      default: result = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Define SEQ_ALU_MOD_EN to enable opcode 0101 (MOD); otherwise it is invalid.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic               err_dz,
  output logic               err_op
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               neg_q, neg_d, err_dz_q, err_dz_d, err_op_q, err_op_d;
  logic               sel_core_q, sel_core_d;
  logic               md_start, md_done;
  md_op_e             md_op;
  logic [2*WIDTH-1:0] md_result, a_ext, b_ext;

  assign a_ext     = {{WIDTH{1'b0}}, a};
  assign b_ext     = {{WIDTH{1'b0}}, b};
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = sel_core_q ? md_result : res_q;
  assign neg       = neg_q;
  assign err_dz    = err_dz_q;
  assign err_op    = err_op_q;

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    neg_d      = neg_q;
    err_dz_d   = err_dz_q;
    err_op_d   = err_op_q;
    sel_core_d = sel_core_q;
    md_start   = 1'b0;
    md_op      = MdMul;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d      = '0;
          neg_d      = 1'b0;
          err_dz_d   = 1'b0;
          err_op_d   = 1'b0;
          sel_core_d = 1'b0;
          state_d    = DONE;
          case (opcode)
            OP_ADD: res_d = a_ext + b_ext;
            OP_SUB: begin
              res_d = a_ext - b_ext;
              neg_d = (a < b);
            end
            OP_MUL: begin
              md_start   = 1'b1;
              sel_core_d = 1'b1;
              state_d    = CALC;
            end
            OP_DIV: begin
              if (b == '0) begin
                err_dz_d = 1'b1;
              end else begin
                md_start   = 1'b1;
                md_op      = MdDiv;
                sel_core_d = 1'b1;
                state_d    = CALC;
              end
            end
`ifdef SEQ_ALU_MOD_EN
            OP_MOD: begin
              if (b == '0) begin
                err_dz_d = 1'b1;
              end else begin
                md_start   = 1'b1;
                md_op      = MdMod;
                sel_core_d = 1'b1;
                state_d    = CALC;
              end
            end
`endif
            default: err_op_d = 1'b1;
          endcase
        end
      end
      CALC: if (md_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      res_q      <= '0;
      neg_q      <= 1'b0;
      err_dz_q   <= 1'b0;
      err_op_q   <= 1'b0;
      sel_core_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      neg_q      <= neg_d;
      err_dz_q   <= err_dz_d;
      err_op_q   <= err_op_d;
      sel_core_q <= sel_core_d;
    end
  end

  alu_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .start  (md_start),
    .op     (md_op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=8): table of ops with expected
// result, flags and latency, plus backpressure and mid-operation reset sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  opcode;
  logic [15:0] result;
  logic        neg, err_dz, err_op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .neg       (neg),
    .err_dz    (err_dz),
    .err_op    (err_op)
  );

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        neg;
    logic        dz;
    logic        eop;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] iop);
    @(negedge clk);
    a        = ia;
    b        = ib;
    opcode   = iop;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 8'hxx;
    b        = 8'hxx;
    opcode   = 4'hx;
  endtask

  // Counts cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    issue(v.a, v.b, v.op);
    wait_out(cyc);
    chk({v.name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({v.name, " latency"}, 32'(cyc), 32'(v.lat));
    chk({v.name, " result"}, 32'(result), 32'(v.res));
    chk({v.name, " flags"}, {29'd0, neg, err_dz, err_op}, {29'd0, v.neg, v.dz, v.eop});
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    vq.push_back('{"add_ff_01", 8'hFF, 8'h01, 4'b0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{"sub_3_5",   8'h03, 8'h05, 4'b0010, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1});
    vq.push_back('{"sub_5_3",   8'h05, 8'h03, 4'b0010, 16'h0002, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{"mul_ff_ff", 8'hFF, 8'hFF, 4'b0100, 16'hFE01, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"mul_0_37",  8'h00, 8'h37, 4'b0100, 16'h0000, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"div_c8_7",  8'hC8, 8'h07, 4'b0011, 16'h001C, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"div_12_0",  8'h12, 8'h00, 4'b0011, 16'h0000, 1'b0, 1'b1, 1'b0, 1});
    vq.push_back('{"op_0111",   8'h12, 8'h34, 4'b0111, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
`ifdef SEQ_ALU_MOD_EN
    vq.push_back('{"mod_c8_7",  8'hC8, 8'h07, 4'b0101, 16'h0004, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"mod_9_0",   8'h09, 8'h00, 4'b0101, 16'h0000, 1'b0, 1'b1, 1'b0, 1});
`else
    vq.push_back('{"mod_off",   8'hC8, 8'h07, 4'b0101, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
`endif
    vq.push_back('{"sub_0_0",   8'h00, 8'h00, 4'b0010, 16'h0000, 1'b0, 1'b0, 1'b0, 1});
    vq.push_back('{"mul_12_34", 8'h12, 8'h34, 4'b0100, 16'h03A8, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"div_ff_1",  8'hFF, 8'h01, 4'b0011, 16'h00FF, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"div_5_9",   8'h05, 8'h09, 4'b0011, 16'h0000, 1'b0, 1'b0, 1'b0, 9});
    vq.push_back('{"op_0000",   8'h01, 8'h01, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1});
    vq.push_back('{"sub_0_ff",  8'h00, 8'hFF, 4'b0010, 16'hFF01, 1'b1, 1'b0, 1'b0, 1});

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", {29'd0, neg, err_dz, err_op}, 32'd0);
    rstn = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // Backpressure: result held, new request stalled until after the drain edge.
    issue(8'h12, 8'h34, 4'b0100);
    wait_out(cyc);
    chk("bp latency", 32'(cyc), 32'd9);
    a        = 8'h01;
    b        = 8'h01;
    opcode   = 4'b0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp result held", 32'(result), 32'h03A8);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp out_valid held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp not accepted on drain", 32'(out_valid), 32'd0);
    chk("bp in_ready after drain", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp queued add valid", 32'(out_valid), 32'd1);
    chk("bp queued add result", 32'(result), 32'h0002);
    drain();

    // Reset during the 4th CALC cycle of a MUL.
    issue(8'hFF, 8'hFF, 4'b0100);
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", {29'd0, neg, err_dz, err_op}, 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) cyc++;
    end
    chk("rst no stale result", 32'(cyc), 32'd0);
    run_vec('{"post_rst_add", 8'h01, 8'h01, 4'b0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
